n101_jtag_pin_conditioner: RTL and testbench
============================================

Name: n101_jtag_pin_conditioner

Overview:
Parametrised successor to the JTAG pin-mux port. It oversamples the raw JTAG pads (TCK/TMS/TDI/TRST_n) in the core clock domain using multi-stage synchronizers. TCK passes through a glitch filter, and the block emits clean TCK level plus rise/fall strobes, TMS/TDI captured on each TCK rise, and a stretched TRST. TDO and its output-enable are retimed onto the filtered TCK falling edge before driving the pad. It sits between the pad ring (GPIO io_pins_* controls) and the debug TAP.

Parameters:
SYNC_STAGES, 2, synchronizer depth per input pin; legal range >= 2.
FILTER_CYCLES, 2, consecutive cycles a new synced TCK level must persist before it is accepted; legal range >= 1, where 1 means no filtering.
TRST_STRETCH, 4, minimum cycles io_jtag_TRST stays high after synced TRST_n returns high; legal range >= 0.
PULLUP, 1, value driven on the pue output of each input pin.
TDO_DS, 0, drive-strength value for the TDO pad.
IDLE_TIMEOUT, 1024, core cycles without a TCK rise before activity drops (optional feature only).

Ports:
clock  in  1  core clock, single domain.
reset  in  1  synchronous, active-high reset.
io_pins_TCK_i_ival / TMS / TDI / TRST_n  in  1 each  raw pad input values.
io_pins_{TCK,TMS,TDI,TRST_n}_o_{oval,oe,ie,pue,ds}  out  1 each  pad controls for the input pins.
io_pins_TDO_i_ival  in  1  unused.
io_pins_TDO_o_{oval,oe,ie,pue,ds}  out  1 each  TDO pad controls.
io_jtag_TCK  out  1  filtered TCK level.
io_jtag_tck_rise  out  1  one-cycle strobe on filtered TCK 0->1.
io_jtag_tck_fall  out  1  one-cycle strobe on filtered TCK 1->0.
io_jtag_TMS  out  1  TMS captured at the TCK rise.
io_jtag_TDI  out  1  TDI captured at the TCK rise.
io_jtag_TRST  out  1  active-high, stretched TAP reset.
io_jtag_TDO  in  1  TDO from the TAP.
io_jtag_DRV_TDO  in  1  TDO drive request from the TAP.
io_jtag_active  out  1  debugger activity flag (see Optional Feature).

Behaviour:
- Reset values:
  - synchronizer flops: TCK 0, TMS 1, TDI 1, TRST_n 0.
  - filtered TCK 0, filter counter 0, rise/fall 0.
  - io_jtag_TMS 1, io_jtag_TDI 1.
  - io_jtag_TRST 1, stretch counter loaded with TRST_STRETCH.
  - TDO oval 0, TDO oe 0.
  - io_jtag_active 0.
- Static pad controls on TCK/TMS/TDI/TRST_n: oval 0, oe 0, ie 1, pue PULLUP, ds 0. TDO pad: ie 0, pue 0, ds TDO_DS.
- Synchronizer: each input passes through SYNC_STAGES flops; s_x is the final-stage value.
- TCK filter:
  - On each edge where s_tck != filt, the counter increments.
  - When the counter reaches FILTER_CYCLES-1 with s_tck still != filt, filt <= s_tck and the counter clears.
  - Any edge where s_tck == filt clears the counter.
  - Latency: a pad level first sampled at edge 0 commits at edge SYNC_STAGES+FILTER_CYCLES-1. Pulses shorter than FILTER_CYCLES cycles are rejected.
- Strobes:
  - io_jtag_tck_rise is registered high for exactly one cycle, in the same cycle filt becomes 1. io_jtag_tck_fall is the same for filt becoming 0.
  - Rise and fall are never both high.
- Capture: at the edge committing a rise, io_jtag_TMS <= s_tms and io_jtag_TDI <= s_tdi. Both values are valid with the rise strobe and hold until the next rise.
- TRST:
  - While s_trst_n == 0: io_jtag_TRST = 1 and the stretch counter reloads to TRST_STRETCH.
  - After s_trst_n returns high, io_jtag_TRST stays 1 until the counter decrements to 0, i.e. TRST_STRETCH extra cycles.
  - With TRST_STRETCH = 0, io_jtag_TRST drops the cycle after s_trst_n is seen high.
- TDO retime:
  - At the edge committing a fall, TDO oval <= io_jtag_TDO and TDO oe <= io_jtag_DRV_TDO. Both hold otherwise.
  - While io_jtag_TRST = 1, TDO oe is cleared to 0 each cycle. TRST has priority over a simultaneous fall.
- Reset mid-transfer: all state returns to reset values at the next edge, and no strobe is emitted that cycle.

Optional Feature:
Macro: N101_JTAG_PIN_ACTIVITY_EN.
- Defined:
  - An idle counter of width clog2(IDLE_TIMEOUT+1) reloads to IDLE_TIMEOUT and sets io_jtag_active = 1 on every rise strobe.
  - Otherwise, while active, the counter decrements; io_jtag_active clears on the edge it reaches 0.
  - io_jtag_TRST = 1 forces io_jtag_active to 0.
- Undefined: no counter logic; io_jtag_active is tied to 0.

Test Plan:
1. Latency: SYNC_STAGES=2, FILTER_CYCLES=3; TCK pad 0->1 sampled at edge 0 -> io_jtag_TCK=1 and rise=1 after edge 4, rise=0 after edge 5.
2. Glitch reject: FILTER_CYCLES=3; 2-cycle TCK high pulse -> io_jtag_TCK stays 0 and no strobes. A 3-cycle pulse -> one rise, then one fall.
3. Capture: TMS=0, TDI=1 held across a TCK rise -> io_jtag_TMS=0, io_jtag_TDI=1 in the rise cycle. Change TMS mid-high-phase -> outputs unchanged until the next rise.
4. TDO retime: DRV_TDO=1, TDO=1 set while TCK high -> pad oval/oe stay 0 until the fall-strobe cycle, then become 1/1.
5. TRST stretch: TRST_STRETCH=4; TRST_n low 10 cycles then high -> io_jtag_TRST high throughout, drops exactly 4 cycles after s_trst_n goes high. TDO oe forced 0 during assertion.
6. Reset/activity: macro on, IDLE_TIMEOUT=8; one TCK rise -> active=1, clears 8 cycles later. A reset pulse mid-high-TCK -> io_jtag_TCK=0, TRST=1, active=0 the next cycle.

Source files
------------

// File: rtl/n101_jtag_pin_conditioner_if.sv
// Pad-ring and TAP-side signals of the JTAG pin conditioner.
// The slave modport is the conditioner's view; master is the pad/TAP side.
interface n101_jtag_pin_conditioner_if;
  logic io_pins_TCK_i_ival,    io_pins_TMS_i_ival,    io_pins_TDI_i_ival;
  logic io_pins_TRST_n_i_ival, io_pins_TDO_i_ival;
  logic io_pins_TCK_o_oval,    io_pins_TCK_o_oe,    io_pins_TCK_o_ie;
  logic io_pins_TCK_o_pue,     io_pins_TCK_o_ds;
  logic io_pins_TMS_o_oval,    io_pins_TMS_o_oe,    io_pins_TMS_o_ie;
  logic io_pins_TMS_o_pue,     io_pins_TMS_o_ds;
  logic io_pins_TDI_o_oval,    io_pins_TDI_o_oe,    io_pins_TDI_o_ie;
  logic io_pins_TDI_o_pue,     io_pins_TDI_o_ds;
  logic io_pins_TRST_n_o_oval, io_pins_TRST_n_o_oe, io_pins_TRST_n_o_ie;
  logic io_pins_TRST_n_o_pue,  io_pins_TRST_n_o_ds;
  logic io_pins_TDO_o_oval,    io_pins_TDO_o_oe,    io_pins_TDO_o_ie;
  logic io_pins_TDO_o_pue,     io_pins_TDO_o_ds;
  logic io_jtag_TCK, io_jtag_tck_rise, io_jtag_tck_fall;
  logic io_jtag_TMS, io_jtag_TDI, io_jtag_TRST;
  logic io_jtag_TDO, io_jtag_DRV_TDO, io_jtag_active;

  modport slave (
    input  io_pins_TCK_i_ival, io_pins_TMS_i_ival, io_pins_TDI_i_ival,
           io_pins_TRST_n_i_ival, io_pins_TDO_i_ival,
           io_jtag_TDO, io_jtag_DRV_TDO,
    output io_pins_TCK_o_oval, io_pins_TCK_o_oe, io_pins_TCK_o_ie,
           io_pins_TCK_o_pue, io_pins_TCK_o_ds,
           io_pins_TMS_o_oval, io_pins_TMS_o_oe, io_pins_TMS_o_ie,
           io_pins_TMS_o_pue, io_pins_TMS_o_ds,
           io_pins_TDI_o_oval, io_pins_TDI_o_oe, io_pins_TDI_o_ie,
           io_pins_TDI_o_pue, io_pins_TDI_o_ds,
           io_pins_TRST_n_o_oval, io_pins_TRST_n_o_oe, io_pins_TRST_n_o_ie,
           io_pins_TRST_n_o_pue, io_pins_TRST_n_o_ds,
           io_pins_TDO_o_oval, io_pins_TDO_o_oe, io_pins_TDO_o_ie,
           io_pins_TDO_o_pue, io_pins_TDO_o_ds,
           io_jtag_TCK, io_jtag_tck_rise, io_jtag_tck_fall,
           io_jtag_TMS, io_jtag_TDI, io_jtag_TRST, io_jtag_active
  );

  modport master (
    output io_pins_TCK_i_ival, io_pins_TMS_i_ival, io_pins_TDI_i_ival,
           io_pins_TRST_n_i_ival, io_pins_TDO_i_ival,
           io_jtag_TDO, io_jtag_DRV_TDO,
    input  io_pins_TCK_o_oval, io_pins_TCK_o_oe, io_pins_TCK_o_ie,
           io_pins_TCK_o_pue, io_pins_TCK_o_ds,
           io_pins_TMS_o_oval, io_pins_TMS_o_oe, io_pins_TMS_o_ie,
           io_pins_TMS_o_pue, io_pins_TMS_o_ds,
           io_pins_TDI_o_oval, io_pins_TDI_o_oe, io_pins_TDI_o_ie,
           io_pins_TDI_o_pue, io_pins_TDI_o_ds,
           io_pins_TRST_n_o_oval, io_pins_TRST_n_o_oe, io_pins_TRST_n_o_ie,
           io_pins_TRST_n_o_pue, io_pins_TRST_n_o_ds,
           io_pins_TDO_o_oval, io_pins_TDO_o_oe, io_pins_TDO_o_ie,
           io_pins_TDO_o_pue, io_pins_TDO_o_ds,
           io_jtag_TCK, io_jtag_tck_rise, io_jtag_tck_fall,
           io_jtag_TMS, io_jtag_TDI, io_jtag_TRST, io_jtag_active
  );
endinterface

// File: rtl/n101_jtag_pin_conditioner.sv
// JTAG pad conditioner: synchronize, glitch-filter TCK, capture TMS/TDI, stretch TRST, retime TDO.
// Optional idle-activity tracking is enabled by defining N101_JTAG_PIN_ACTIVITY_EN.
module n101_jtag_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_q;

  always_ff @(posedge clock) begin
    if (reset) r_q <= {SYNC_STAGES{RST_VAL}};
    else       r_q <= {r_q[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_q[SYNC_STAGES-1];
endmodule

module n101_jtag_pin_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int TRST_STRETCH  = 4,
  parameter bit PULLUP        = 1'b1,
  parameter bit TDO_DS        = 1'b0,
  parameter int IDLE_TIMEOUT  = 1024
) (
  input  logic clock,
  input  logic reset,
  n101_jtag_pin_conditioner_if.slave bus
);
  localparam int NPIN = 4;
  localparam int CW   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int SW   = (TRST_STRETCH > 0) ? $clog2(TRST_STRETCH + 1) : 1;
  // Pin order {TRST_n, TDI, TMS, TCK}; reset levels are the idle/asserted-reset pad states.
  localparam logic [NPIN-1:0] SYNC_RST = 4'b0110;

  logic [NPIN-1:0] w_pad;
  logic [NPIN-1:0] w_sync;
  logic            w_s_tck, w_s_tms, w_s_tdi, w_s_trst_n;

  assign w_pad = {bus.io_pins_TRST_n_i_ival, bus.io_pins_TDI_i_ival,
                  bus.io_pins_TMS_i_ival,    bus.io_pins_TCK_i_ival};

  for (genvar g = 0; g < NPIN; g++) begin : g_sync
    n101_jtag_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
      .clock (clock),
      .reset (reset),
      .i_d   (w_pad[g]),
      .o_q   (w_sync[g])
    );
  end

  assign {w_s_trst_n, w_s_tdi, w_s_tms, w_s_tck} = w_sync;

  logic          r_filt, r_rise, r_fall, r_tms, r_tdi;
  logic [CW-1:0] r_fcnt;
  logic          w_commit, w_rise_commit, w_fall_commit;

  assign w_commit      = (w_s_tck != r_filt) && (r_fcnt == CW'(FILTER_CYCLES - 1));
  assign w_rise_commit = w_commit &&  w_s_tck;
  assign w_fall_commit = w_commit && !w_s_tck;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_tms  <= 1'b1;
      r_tdi  <= 1'b1;
    end else begin
      r_rise <= w_rise_commit;
      r_fall <= w_fall_commit;
      if (w_s_tck == r_filt) begin
        r_fcnt <= '0;
      end else if (w_commit) begin
        r_filt <= w_s_tck;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
      if (w_rise_commit) begin
        r_tms <= w_s_tms;
        r_tdi <= w_s_tdi;
      end
    end
  end

  logic          r_trst;
  logic [SW-1:0] r_scnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_trst <= 1'b1;
      r_scnt <= SW'(TRST_STRETCH);
    end else if (!w_s_trst_n) begin
      r_trst <= 1'b1;
      r_scnt <= SW'(TRST_STRETCH);
    end else if (r_scnt != '0) begin
      r_trst <= 1'b1;
      r_scnt <= r_scnt - 1'b1;
    end else begin
      r_trst <= 1'b0;
    end
  end

  logic r_tdo_oval, r_tdo_oe;

  // TRST wins over a coincident fall so the pad never drives during TAP reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tdo_oval <= 1'b0;
      r_tdo_oe   <= 1'b0;
    end else if (r_trst) begin
      r_tdo_oe   <= 1'b0;
    end else if (w_fall_commit) begin
      r_tdo_oval <= bus.io_jtag_TDO;
      r_tdo_oe   <= bus.io_jtag_DRV_TDO;
    end
  end

`ifdef N101_JTAG_PIN_ACTIVITY_EN
  localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  logic [IW-1:0] r_icnt;
  logic          r_active;

  always_ff @(posedge clock) begin
    if (reset || r_trst) begin
      r_icnt   <= '0;
      r_active <= 1'b0;
    end else if (r_rise) begin
      r_icnt   <= IW'(IDLE_TIMEOUT);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_icnt <= r_icnt - 1'b1;
      if (r_icnt <= IW'(1)) r_active <= 1'b0;
    end
  end

  assign bus.io_jtag_active = r_active;
  logic w_unused;
  assign w_unused = bus.io_pins_TDO_i_ival;
`else
  localparam int UNUSED_IDLE = IDLE_TIMEOUT;
  logic w_unused;
  assign w_unused = bus.io_pins_TDO_i_ival ^ (UNUSED_IDLE == 0);
  assign bus.io_jtag_active = 1'b0;
`endif

  assign bus.io_jtag_TCK      = r_filt;
  assign bus.io_jtag_tck_rise = r_rise;
  assign bus.io_jtag_tck_fall = r_fall;
  assign bus.io_jtag_TMS      = r_tms;
  assign bus.io_jtag_TDI      = r_tdi;
  assign bus.io_jtag_TRST     = r_trst;

  assign bus.io_pins_TCK_o_oval    = 1'b0;
  assign bus.io_pins_TCK_o_oe      = 1'b0;
  assign bus.io_pins_TCK_o_ie      = 1'b1;
  assign bus.io_pins_TCK_o_pue     = PULLUP;
  assign bus.io_pins_TCK_o_ds      = 1'b0;
  assign bus.io_pins_TMS_o_oval    = 1'b0;
  assign bus.io_pins_TMS_o_oe      = 1'b0;
  assign bus.io_pins_TMS_o_ie      = 1'b1;
  assign bus.io_pins_TMS_o_pue     = PULLUP;
  assign bus.io_pins_TMS_o_ds      = 1'b0;
  assign bus.io_pins_TDI_o_oval    = 1'b0;
  assign bus.io_pins_TDI_o_oe      = 1'b0;
  assign bus.io_pins_TDI_o_ie      = 1'b1;
  assign bus.io_pins_TDI_o_pue     = PULLUP;
  assign bus.io_pins_TDI_o_ds      = 1'b0;
  assign bus.io_pins_TRST_n_o_oval = 1'b0;
  assign bus.io_pins_TRST_n_o_oe   = 1'b0;
  assign bus.io_pins_TRST_n_o_ie   = 1'b1;
  assign bus.io_pins_TRST_n_o_pue  = PULLUP;
  assign bus.io_pins_TRST_n_o_ds   = 1'b0;
  assign bus.io_pins_TDO_o_oval    = r_tdo_oval;
  assign bus.io_pins_TDO_o_oe      = r_tdo_oe;
  assign bus.io_pins_TDO_o_ie      = 1'b0;
  assign bus.io_pins_TDO_o_pue     = 1'b0;
  assign bus.io_pins_TDO_o_ds      = TDO_DS;
endmodule

// File: tb/tb_n101_jtag_pin_conditioner.sv
// Scoreboard bench: stimulus queues cycle-stamped level checks and expected strobes; a negedge monitor compares.
module tb_n101_jtag_pin_conditioner;
  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  n101_jtag_pin_conditioner_if bus();

  n101_jtag_pin_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(3), .TRST_STRETCH(4),
    .PULLUP(1'b1), .TDO_DS(1'b0), .IDLE_TIMEOUT(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef N101_JTAG_PIN_ACTIVITY_EN
  localparam bit ACT_ON = 1'b1;
`else
  localparam bit ACT_ON = 1'b0;
`endif

  localparam int B_TCK = 0, B_RISE = 1, B_FALL = 2, B_TMS = 3, B_TDI = 4;
  localparam int B_TRST = 5, B_OVAL = 6, B_OE = 7, B_ACT = 8;

  typedef struct {
    int         cyc;
    int         bitn;
    logic       val;
    string      name;
  } lvl_t;

  typedef struct {
    logic rise;
    logic tms;
    logic tdi;
  } stb_t;

  lvl_t lq[$];
  stb_t sq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic exp_bit(input int c, input int b, input logic v, input string nm);
    lvl_t e;
    e.cyc = c; e.bitn = b; e.val = v; e.name = nm;
    lq.push_back(e);
  endtask

  task automatic exp_stb(input logic r, input logic tms, input logic tdi);
    stb_t s;
    s.rise = r; s.tms = tms; s.tdi = tdi;
    sq.push_back(s);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  // Monitor: level checks at their stamped cycle, strobes in issue order.
  always @(negedge clock) begin
    logic [8:0] o;
    stb_t s;
    o = {bus.io_jtag_active, bus.io_pins_TDO_o_oe, bus.io_pins_TDO_o_oval,
         bus.io_jtag_TRST, bus.io_jtag_TDI, bus.io_jtag_TMS,
         bus.io_jtag_tck_fall, bus.io_jtag_tck_rise, bus.io_jtag_TCK};
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].cyc == cyc) begin
        n_chk++;
        if (o[lq[i].bitn] === lq[i].val) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b want=%b", lq[i].name, cyc,
                      o[lq[i].bitn], lq[i].val);
        lq.delete(i);
      end
    end
    if (o[B_RISE] === 1'b1 || o[B_FALL] === 1'b1) begin
      n_chk++;
      if (o[B_RISE] && o[B_FALL]) begin
        $display("FAIL strobe_both cyc=%0d got rise=1 fall=1 want exclusive", cyc);
      end else if (sq.size() == 0) begin
        $display("FAIL strobe_unexpected cyc=%0d got rise=%b fall=%b want none",
                 cyc, o[B_RISE], o[B_FALL]);
      end else begin
        s = sq.pop_front();
        if (o[B_RISE] == s.rise && o[B_TMS] === s.tms && o[B_TDI] === s.tdi) n_pass++;
        else $display("FAIL strobe cyc=%0d got rise/tms/tdi=%b%b%b want %b%b%b", cyc,
                      o[B_RISE], o[B_TMS], o[B_TDI], s.rise, s.tms, s.tdi);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1);
  end

  initial begin
    int now;
    reset = 1'b1;
    bus.io_pins_TCK_i_ival = 1'b0; bus.io_pins_TMS_i_ival = 1'b1;
    bus.io_pins_TDI_i_ival = 1'b1; bus.io_pins_TRST_n_i_ival = 1'b1;
    bus.io_pins_TDO_i_ival = 1'b0;
    bus.io_jtag_TDO = 1'b0; bus.io_jtag_DRV_TDO = 1'b0;

    // reset state
    tick(1); now = cyc;
    exp_bit(now + 1, B_TCK, 0, "rst_tck");   exp_bit(now + 1, B_RISE, 0, "rst_rise");
    exp_bit(now + 1, B_FALL, 0, "rst_fall"); exp_bit(now + 1, B_TMS, 1, "rst_tms");
    exp_bit(now + 1, B_TDI, 1, "rst_tdi");   exp_bit(now + 1, B_TRST, 1, "rst_trst");
    exp_bit(now + 1, B_OVAL, 0, "rst_oval"); exp_bit(now + 1, B_OE, 0, "rst_oe");
    exp_bit(now + 1, B_ACT, 0, "rst_act");
    tick(3); reset = 1'b0; now = cyc;
    exp_bit(now + 6, B_TRST, 1, "boot_trst_hold");
    exp_bit(now + 7, B_TRST, 0, "boot_trst_drop");
    tick(10);

    // latency, capture, activity
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b1; bus.io_pins_TMS_i_ival = 1'b0; bus.io_pins_TDI_i_ival = 1'b1;
    exp_stb(1, 0, 1);
    exp_bit(now + 4, B_TCK, 0, "lat_tck_early"); exp_bit(now + 4, B_RISE, 0, "lat_rise_early");
    exp_bit(now + 5, B_TCK, 1, "lat_tck");       exp_bit(now + 5, B_RISE, 1, "lat_rise");
    exp_bit(now + 5, B_TMS, 0, "cap_tms");       exp_bit(now + 5, B_TDI, 1, "cap_tdi");
    exp_bit(now + 5, B_ACT, 0, "act_pre");
    exp_bit(now + 6, B_RISE, 0, "lat_rise_one"); exp_bit(now + 6, B_TCK, 1, "lat_tck_hold");
    exp_bit(now + 6, B_ACT, ACT_ON, "act_set");  exp_bit(now + 13, B_ACT, ACT_ON, "act_last");
    exp_bit(now + 14, B_ACT, 0, "act_clear");
    tick(6);
    bus.io_pins_TMS_i_ival = 1'b1; bus.io_pins_TDI_i_ival = 1'b0;
    bus.io_jtag_TDO = 1'b1; bus.io_jtag_DRV_TDO = 1'b1;
    exp_bit(now + 10, B_TMS, 0, "cap_tms_hold"); exp_bit(now + 10, B_TDI, 1, "cap_tdi_hold");
    exp_bit(now + 10, B_OVAL, 0, "tdo_oval_wait"); exp_bit(now + 10, B_OE, 0, "tdo_oe_wait");
    tick(6);

    // TDO retime on fall
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b0;
    exp_stb(0, 0, 1);
    exp_bit(now + 4, B_OVAL, 0, "tdo_oval_pre"); exp_bit(now + 4, B_OE, 0, "tdo_oe_pre");
    exp_bit(now + 5, B_FALL, 1, "fall_strobe");  exp_bit(now + 5, B_TCK, 0, "fall_tck");
    exp_bit(now + 5, B_OVAL, 1, "tdo_oval");     exp_bit(now + 5, B_OE, 1, "tdo_oe");
    exp_bit(now + 6, B_FALL, 0, "fall_one");
    exp_bit(now + 8, B_OVAL, 1, "tdo_oval_hold");
    tick(6); bus.io_jtag_TDO = 1'b0;
    tick(4);

    // second rise picks up the mid-phase TMS/TDI change
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b1;
    exp_stb(1, 1, 0);
    exp_bit(now + 5, B_TMS, 1, "cap2_tms"); exp_bit(now + 5, B_TDI, 0, "cap2_tdi");
    tick(10);
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b0;
    exp_stb(0, 1, 0);
    exp_bit(now + 5, B_OVAL, 0, "tdo2_oval"); exp_bit(now + 5, B_OE, 1, "tdo2_oe");
    tick(10);

    // glitch reject (2 cycles) then accept (3 cycles)
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b1; tick(2); bus.io_pins_TCK_i_ival = 1'b0;
    for (int k = 4; k <= 7; k++) exp_bit(now + k, B_TCK, 0, "glitch_tck");
    tick(10);
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b1;
    exp_stb(1, 1, 0);
    tick(3); bus.io_pins_TCK_i_ival = 1'b0;
    exp_stb(0, 1, 0);
    exp_bit(now + 5, B_RISE, 1, "p3_rise"); exp_bit(now + 7, B_TCK, 1, "p3_tck_hi");
    exp_bit(now + 8, B_FALL, 1, "p3_fall"); exp_bit(now + 8, B_TCK, 0, "p3_tck_lo");
    tick(12);

    // TRST stretch and oe override
    now = cyc;
    bus.io_pins_TRST_n_i_ival = 1'b0;
    exp_bit(now + 2, B_TRST, 0, "trst_pre"); exp_bit(now + 3, B_TRST, 1, "trst_on");
    exp_bit(now + 3, B_OE, 1, "trst_oe_pre"); exp_bit(now + 4, B_OE, 0, "trst_oe_clr");
    tick(10);
    now = cyc;
    bus.io_pins_TRST_n_i_ival = 1'b1;
    exp_bit(now + 6, B_TRST, 1, "trst_stretch"); exp_bit(now + 6, B_OE, 0, "trst_oe_hold");
    exp_bit(now + 7, B_TRST, 0, "trst_drop");
    tick(12);

    // reset mid high TCK
    now = cyc;
    bus.io_pins_TCK_i_ival = 1'b1; bus.io_pins_TMS_i_ival = 1'b0; bus.io_pins_TDI_i_ival = 1'b1;
    exp_stb(1, 0, 1);
    exp_bit(now + 6, B_ACT, ACT_ON, "mid_act");
    tick(8);
    reset = 1'b1; bus.io_pins_TCK_i_ival = 1'b0;
    exp_bit(now + 9, B_TCK, 0, "mid_rst_tck");   exp_bit(now + 9, B_TRST, 1, "mid_rst_trst");
    exp_bit(now + 9, B_ACT, 0, "mid_rst_act");   exp_bit(now + 9, B_TMS, 1, "mid_rst_tms");
    exp_bit(now + 9, B_FALL, 0, "mid_rst_fall"); exp_bit(now + 9, B_OE, 0, "mid_rst_oe");
    tick(2); reset = 1'b0;
    exp_bit(now + 16, B_TRST, 1, "mid_trst_hold"); exp_bit(now + 17, B_TRST, 0, "mid_trst_drop");
    tick(20);

    @(negedge clock); #1;
    if (lq.size() != 0) begin
      n_chk += lq.size();
      $display("FAIL pending_levels got %0d unchecked want 0", lq.size());
    end
    n_chk++;
    if (sq.size() == 0) n_pass++;
    else $display("FAIL missing_strobes got %0d outstanding want 0", sq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
